// File: rtl/image_ram_writer.sv
// image_ram_writer
// Unpacks a valid/ready byte stream (8 pixels per byte, MSB = leftmost pixel)
// into single-bit writes to the 1-bit image RAM. Writes go to raster addresses
// starting at 0 on each start-of-frame byte. Runs entirely in pixel_clk.
module image_ram_writer #(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256,
    parameter int ADDR_W     = 16
) (
    input  logic              pixel_clk,
    input  logic              sys_rst_n,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_sof,
    output logic              s_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_din,
    output logic              frame_done,
    output logic              sof_err,
    output logic              busy,
    output logic [7:0]        frame_cnt
);

    localparam int                TOTAL     = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        shreg, shreg_nxt;
    logic [3:0]        bits_left, bits_left_nxt;
    logic [ADDR_W-1:0] pix_addr, pix_addr_nxt;

    logic              accept;
    logic              wr_bit;
    logic              last_bit;

    logic              ram_we_nxt;
    logic [ADDR_W-1:0] ram_addr_nxt;
    logic              ram_din_nxt;
    logic              frame_done_nxt;
    logic              sof_err_nxt;
    logic [7:0]        frame_cnt_nxt;

    // Ready while at most one bit is still waiting to be written, so the next
    // byte can load on the same edge as the final write of the current one.
    assign s_ready = (bits_left == 4'd0) || (bits_left == 4'd1);
    assign accept  = s_valid && s_ready;
    assign busy    = (state == ACTIVE);

    // Next-state: bit write/shift, byte load, frame end and mid-frame SOF handling.
    always_comb begin
        wr_bit   = (state == ACTIVE) && (bits_left != 4'd0);
        last_bit = wr_bit && (pix_addr == LAST_ADDR);

        state_nxt      = state;
        shreg_nxt      = shreg;
        bits_left_nxt  = bits_left;
        pix_addr_nxt   = pix_addr;
        ram_we_nxt     = wr_bit;
        ram_addr_nxt   = wr_bit ? pix_addr : ram_addr;
        ram_din_nxt    = wr_bit ? shreg[7] : ram_din;
        frame_done_nxt = last_bit;
        sof_err_nxt    = 1'b0;
        frame_cnt_nxt  = frame_cnt + {7'd0, last_bit};

        // The in-flight bit always goes out at its old address, even when a
        // byte is accepted on the same edge.
        if (wr_bit) begin
            shreg_nxt     = {shreg[6:0], 1'b0};
            bits_left_nxt = bits_left - 4'd1;
            pix_addr_nxt  = last_bit ? '0 : pix_addr + 1'b1;
            if (last_bit) begin
                state_nxt = IDLE;
            end
        end

        if (accept) begin
            if ((state == IDLE) || last_bit) begin
                // Outside a frame only a start-of-frame byte is kept.
                if (s_sof) begin
                    state_nxt     = ACTIVE;
                    shreg_nxt     = s_data;
                    bits_left_nxt = 4'd8;
                    pix_addr_nxt  = '0;
                end
            end else begin
                shreg_nxt     = s_data;
                bits_left_nxt = 4'd8;
                // A new SOF inside an unfinished frame restarts at address 0.
                if (s_sof) begin
                    sof_err_nxt  = 1'b1;
                    pix_addr_nxt = '0;
                end
            end
        end
    end

    // Control state and registered RAM-port outputs, cleared asynchronously.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            bits_left  <= 4'd0;
            pix_addr   <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= 1'b0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            state      <= state_nxt;
            bits_left  <= bits_left_nxt;
            pix_addr   <= pix_addr_nxt;
            ram_we     <= ram_we_nxt;
            ram_addr   <= ram_addr_nxt;
            ram_din    <= ram_din_nxt;
            frame_done <= frame_done_nxt;
            sof_err    <= sof_err_nxt;
            frame_cnt  <= frame_cnt_nxt;
        end
    end

    // Pixel shift register; contents only matter while bits_left is non-zero.
    always_ff @(posedge pixel_clk) begin
        shreg <= shreg_nxt;
    end

endmodule

// File: tb/tb_image_ram_writer.sv
// Testbench for image_ram_writer: byte-level reference model plus literal checks.
module tb_image_ram_writer;

    localparam int W      = 64;
    localparam int H      = 32;
    localparam int AW     = 11;
    localparam int TOTAL  = W * H;
    localparam int BYTES  = TOTAL / 8;

    logic          pixel_clk;
    logic          sys_rst_n;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_sof;
    logic          s_ready;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic          ram_din;
    logic          frame_done;
    logic          sof_err;
    logic          busy;
    logic [7:0]    frame_cnt;

    image_ram_writer #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .ADDR_W    (AW)
    ) dut (
        .pixel_clk (pixel_clk),
        .sys_rst_n (sys_rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_sof     (s_sof),
        .s_ready   (s_ready),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .frame_done(frame_done),
        .sof_err   (sof_err),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected writes derived from accepted bytes.
    typedef struct {
        int addr;
        bit din;
        bit done;
    } wr_t;
    typedef struct {
        int addr;
        bit din;
    } obs_t;

    wr_t  mq[$];
    obs_t wlog[$];
    bit   m_active = 0;
    int   m_bytes  = 0;
    int   m_cnt    = 0;
    bit   acc_q    = 0;
    logic [7:0] acc_d;
    bit   acc_sof;
    int   we_run   = 0;
    int   done_run = 0;
    int   sof_cnt  = 0;
    int   fd_cnt   = 0;

    always @(negedge pixel_clk) begin : monitor
        wr_t  w;
        obs_t o;
        bit   exp_we;
        bit   exp_se;
        if (!sys_rst_n) begin
            mq.delete();
            m_active = 0;
            m_bytes  = 0;
            m_cnt    = 0;
            acc_q    = 0;
            we_run   = 0;
        end else begin
            // Write registered at the previous edge.
            exp_we = (mq.size() > 0);
            chk("ram_we", ram_we, exp_we);
            if (exp_we) begin
                w = mq.pop_front();
                chk("ram_addr", ram_addr, w.addr);
                chk("ram_din", ram_din, w.din);
                chk("frame_done", frame_done, w.done);
                if (w.done) m_cnt = (m_cnt + 1) % 256;
            end else begin
                chk("frame_done_idle", frame_done, 0);
            end
            // Byte accepted at the previous edge.
            exp_se = 0;
            if (acc_q) begin
                if (acc_sof) begin
                    if (m_active) exp_se = 1;
                    m_active = 1;
                    m_bytes  = 0;
                end
                if (m_active) begin
                    for (int i = 0; i < 8; i++) begin
                        w.addr = m_bytes * 8 + i;
                        w.din  = acc_d[7-i];
                        w.done = (m_bytes == BYTES - 1) && (i == 7);
                        mq.push_back(w);
                    end
                    m_bytes++;
                    if (m_bytes == BYTES) m_active = 0;
                end
            end
            chk("sof_err", sof_err, exp_se);
            chk("fd_se_excl", frame_done & sof_err, 0);
            chk("busy", busy, (m_active || mq.size() > 0));
            chk("frame_cnt", frame_cnt, m_cnt);
            chk("s_ready", s_ready, (mq.size() <= 1));
            if (ram_we) begin
                o.addr = ram_addr;
                o.din  = ram_din;
                wlog.push_back(o);
                we_run++;
            end else begin
                we_run = 0;
            end
            if (frame_done) begin
                done_run = we_run;
                fd_cnt++;
            end
            if (sof_err) sof_cnt++;
            acc_q   = s_valid && s_ready;
            acc_d   = s_data;
            acc_sof = s_sof;
        end
    end

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge pixel_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic sof, input bit rnd);
        int guard;
        guard   = 0;
        s_data  = d;
        s_sof   = sof;
        s_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        forever begin
            @(negedge pixel_clk);
            if (s_valid && s_ready) break;
            guard++;
            if (guard > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
                break;
            end
            @(posedge pixel_clk);
            #1;
            if (rnd) s_valid = ($urandom_range(0, 2) != 0);
        end
        @(posedge pixel_clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        forever begin
            @(negedge pixel_clk);
            if (frame_done) break;
            n++;
            if (n > max) begin
                checks++;
                errors++;
                $display("FAIL wait_done_timeout: got no frame_done expected pulse within %0d cycles", max);
                break;
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_we"}, ram_we, 0);
        chk({tag, "_addr"}, ram_addr, 0);
        chk({tag, "_din"}, ram_din, 0);
        chk({tag, "_fd"}, frame_done, 0);
        chk({tag, "_se"}, sof_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cnt"}, frame_cnt, 0);
        chk({tag, "_ready"}, s_ready, 1);
    endtask

    int exp_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int base;
    logic sof_r;

    initial begin
        sys_rst_n = 1'b0;
        s_valid   = 1'b0;
        s_data    = 8'd0;
        s_sof     = 1'b0;
        repeat (3) @(posedge pixel_clk);
        #1;
        chk_reset_vals("rst0");
        sys_rst_n = 1'b1;
        idle(2);

        // Non-SOF byte in IDLE is dropped.
        wlog.delete();
        send_byte(8'hFF, 1'b0, 1'b0);
        idle(4);
        @(negedge pixel_clk);
        chk("drop_writes", wlog.size(), 0);
        chk("drop_busy", busy, 0);

        // Full frame with continuous valid, first byte 0xA5.
        @(posedge pixel_clk);
        #1;
        base = fd_cnt;
        send_byte(8'hA5, 1'b1, 1'b0);
        for (int i = 1; i < BYTES; i++) send_byte(8'($urandom), 1'b0, 1'b0);
        wait_done(TOTAL + 100);
        @(negedge pixel_clk);
        chk("full_nwrites", wlog.size(), TOTAL);
        if (wlog.size() >= TOTAL) begin
            for (int i = 0; i < 8; i++) begin
                chk("bitorder_addr", wlog[i].addr, i);
                chk("bitorder_din", wlog[i].din, exp_bits[i]);
            end
            chk("full_last_addr", wlog[TOTAL-1].addr, TOTAL - 1);
        end
        chk("full_run", done_run, TOTAL);
        chk("full_fd_pulses", fd_cnt - base, 1);
        chk("full_frame_cnt", frame_cnt, 1);
        chk("full_busy_after", busy, 0);

        // SOF mid-frame after 101 bytes.
        @(posedge pixel_clk);
        #1;
        wlog.delete();
        base = sof_cnt;
        send_byte(8'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) send_byte(8'($urandom), 1'b0, 1'b0);
        send_byte(8'h80, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1'b0, 1'b0);
        @(negedge pixel_clk);
        chk("midsof_pulses", sof_cnt - base, 1);
        chk("midsof_nwrites_ok", (wlog.size() > 809), 1);
        if (wlog.size() > 809) begin
            chk("midsof_inflight_addr", wlog[807].addr, 807);
            chk("midsof_restart_addr", wlog[808].addr, 0);
            chk("midsof_restart_din", wlog[808].din, 1);
        end
        chk("midsof_frame_cnt", frame_cnt, 1);
        chk("midsof_busy", busy, 1);

        // Asynchronous reset mid-frame.
        @(posedge pixel_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        repeat (3) @(posedge pixel_clk);
        #1;
        sys_rst_n = 1'b1;
        wlog.delete();
        send_byte(8'h3C, 1'b0, 1'b0);
        idle(4);
        @(negedge pixel_clk);
        chk("postrst_drop_writes", wlog.size(), 0);
        chk("postrst_busy", busy, 0);
        chk("postrst_cnt", frame_cnt, 0);

        // Full frame with random valid gaps after reset.
        @(posedge pixel_clk);
        #1;
        send_byte(8'($urandom), 1'b1, 1'b1);
        for (int i = 1; i < BYTES; i++) send_byte(8'($urandom), 1'b0, 1'b1);
        wait_done(TOTAL * 4);
        @(negedge pixel_clk);
        chk("postrst_frame_cnt", frame_cnt, 1);
        chk("postrst_busy_after", busy, 0);

        // Random stream with occasional SOF and gaps.
        @(posedge pixel_clk);
        #1;
        for (int i = 0; i < 400; i++) begin
            sof_r = (i == 0) || ($urandom_range(0, 49) == 0);
            send_byte(8'($urandom), sof_r, 1'b1);
        end
        idle(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
